// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: integer baud divider plus start/data/stop frame sequencer.
// Upstream hands bytes over a valid/ready handshake, and the frame is shifted out LSB first on tx.
module uart_tx_ctrl #(
  parameter int CLK_IN_FREQ = 50_000_000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 baud_tick
);

  // state | meaning
  // IDLE  | line high, ready for a byte
  // START | start bit (tx=0) for one bit period
  // DATA  | data bits, LSB first, one per bit period
  // STOP  | stop bit (tx=1) for one bit period

  localparam int DIV = CLK_IN_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_ctrl: CLK_IN_FREQ / BAUD must be at least 2");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 accept, tx_nxt, ready_nxt;

  assign busy      = (state != IDLE);
  assign baud_tick = busy & (cnt == CW'(DIV - 1));
  assign accept    = tx_valid & tx_ready;

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= 1'b1;
      tx_ready <= 1'b0;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      tx       <= tx_nxt;
      tx_ready <= ready_nxt;
      shreg    <= shreg_nxt;
      if (!busy || baud_tick) cnt <= '0;
      else                    cnt <= cnt + 1'b1;
      if (state != DATA)      bit_idx <= '0;
      else if (baud_tick)     bit_idx <= bit_idx + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    case (state)
      IDLE: if (accept) begin
        state_nxt = START;
        shreg_nxt = tx_data;
      end
      START: if (baud_tick) state_nxt = DATA;
      DATA: if (baud_tick) begin
        shreg_nxt = shreg >> 1;
        if (bit_idx == IW'(DATA_BITS - 1)) state_nxt = STOP;
      end
      STOP: if (baud_tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // tx and tx_ready are registered, so decode them from the state being entered
  always_comb begin
    tx_nxt    = 1'b1;
    ready_nxt = 1'b0;
    case (state_nxt)
      IDLE:    ready_nxt = 1'b1;
      START:   tx_nxt    = 1'b0;
      DATA:    tx_nxt    = shreg_nxt[0];
      STOP:    tx_nxt    = 1'b1;
      default: tx_nxt    = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a fast instance (DIV=10) with a table of frames and corner cases,
// plus a default-parameter instance for full-rate bit-period timing.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx, busy, baud_tick;
  logic [7:0] tx_data2 = 8'h00;
  logic       tx_valid2 = 1'b0;
  logic       tx_ready2, tx2, busy2, baud_tick2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_IN_FREQ(1000), .BAUD(100), .DATA_BITS(8)) dut (
    .clk_in(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .busy(busy), .baud_tick(baud_tick)
  );

  uart_tx_ctrl dut_def (
    .clk_in(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx(tx2), .busy(busy2), .baud_tick(baud_tick2)
  );

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;  // bit i = level of line bit i: start, d0..d7, stop
    string      name;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (tx_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(tx_ready), 1);
  endtask

  // Called on the negedge right after the accepting edge; ends on the edge where IDLE is re-entered.
  task automatic check_frame(input logic [9:0] line, input string nm);
    int bad_bits = 0, ticks = 0, bad_flags = 0;
    for (int j = 0; j <= 100; j++) begin
      if (j > 0) @(negedge clk);
      if (j < 100) begin
        if (tx !== line[j / 10]) bad_bits++;
        if (tx_ready !== 1'b0 || busy !== 1'b1) bad_flags++;
        if (baud_tick === 1'b1) ticks++;
      end else begin
        check({nm, "_end_ready_busy_tx"}, 32'({tx_ready, busy, tx}), 32'b101);
      end
    end
    check({nm, "_bad_bit_samples"}, 32'(bad_bits), 0);
    check({nm, "_busy_ready_in_frame"}, 32'(bad_flags), 0);
    check({nm, "_tick_count"}, 32'(ticks), 10);
  endtask

  task automatic send(input logic [7:0] d);
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0, "a5"};
    vecs[1] = '{8'h01, 10'b1_00000001_0, "01"};
    vecs[2] = '{8'h80, 10'b1_10000000_0, "80"};
    vecs[3] = '{8'h3C, 10'b1_00111100_0, "3c"};
    vecs[4] = '{8'hFF, 10'b1_11111111_0, "ff"};

    // reset held 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_outputs", 32'({tx, tx_ready, busy, baud_tick}), 32'b1000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'({tx_ready, busy, tx}), 32'b101);

    // table of single frames
    foreach (vecs[i]) begin
      send(vecs[i].data);
      check_frame(vecs[i].line, vecs[i].name);
    end

    // back-to-back 0x00 then 0xFF with valid held
    begin
      int high_run = 0, second_start = -1;
      wait_ready();
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_data = 8'hFF;
      for (int j = 0; j <= 101; j++) begin
        if (j > 0) @(negedge clk);
        if (j >= 90 && tx === 1'b1) high_run++;
        if (j > 90 && tx === 1'b0 && second_start < 0) second_start = j;
      end
      tx_valid = 1'b0;
      check("b2b_second_start", 32'(second_start), 101);
      check("b2b_gap_high", 32'(high_run), 11);
      check_frame(10'b1_11111111_0, "b2b_ff");
    end

    // reset at cycle 35 of a 0x00 frame
    begin
      int bad = 0;
      send(8'h00);
      repeat (35) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset_outputs", 32'({tx, busy, tx_ready}), 32'b100);
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset_ready", 32'({tx_ready, busy, tx}), 32'b101);
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if ({tx, busy, tx_ready, baud_tick} !== 4'b1010) bad++;
      end
      check("midreset_idle_line", 32'(bad), 0);
    end

    // busy-time valid/data activity must be ignored
    begin
      int bad = 0;
      send(8'h96);
      fork
        check_frame(10'b1_10010110_0, "ignore_96");
        begin
          tx_data = 8'h3C;
          for (int j = 0; j < 95; j++) begin
            tx_valid = ~tx_valid;
            @(negedge clk);
          end
          tx_valid = 1'b0;
        end
      join
      for (int j = 0; j < 5; j++) begin
        @(negedge clk);
        if (busy !== 1'b0) bad++;
      end
      check("ignore_no_accept", 32'(bad), 0);
    end

    // default parameters: 0x55 alternates every bit, so each run is one bit period
    begin
      int runlen = 1, transitions = 0, frame_len = -1, bad_runs = 0, ticks = 0;
      logic cur;
      tx_data2  = 8'h55;
      tx_valid2 = 1'b1;
      @(negedge clk);
      tx_valid2 = 1'b0;
      cur = tx2;
      check("def_start_bit", 32'(tx2), 0);
      if (baud_tick2 === 1'b1) ticks++;
      for (int j = 1; j <= 52200 && frame_len < 0; j++) begin
        @(negedge clk);
        if (tx_ready2 === 1'b1) frame_len = j;
        else begin
          if (baud_tick2 === 1'b1) ticks++;
          if (tx2 !== cur) begin
            if (runlen != 5208) begin
              bad_runs++;
              $display("FAIL def_bit_period: got %0d expected 5208", runlen);
            end
            transitions++;
            cur    = tx2;
            runlen = 1;
          end else runlen++;
        end
      end
      check("def_bit_periods", 32'(bad_runs), 0);
      check("def_transitions", 32'(transitions), 9);
      check("def_stop_period", 32'(runlen), 5208);
      check("def_frame_len", 32'(frame_len), 52080);
      check("def_ticks", 32'(ticks), 10);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
